// File: rtl/dest_rx_pkg.sv
// dest_rx_pkg: word field positions and FSM state encodings shared by
// dest_rx_drain and its testbench-facing logic.
package dest_rx_pkg;

    // Word layout: [5] virtual channel, [4] destination port, [3:0] payload.
    localparam int VC_BIT      = 5;
    localparam int DEST_BIT    = 4;
    localparam int PAYLOAD_MSB = 3;
    localparam int PAYLOAD_LSB = 0;

    // Drain FSM states; the encoding is fixed so waveforms read the same
    // in every build.
    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_ERROR  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter. The pointer names the
// preferred requester when both ask; it toggles on every advance, and a
// lone requester is always granted regardless of the pointer.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       clear_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o,
    output logic       ptr_o
);

    logic ptr_q;
    logic ptr_d;

    // Grant selection: contention resolved by the pointer, otherwise pass the request.
    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end
    end

    // Pointer next state: flips after each granted pop.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = ~ptr_q;
        end
    end

    // Pointer register; clear returns preference to port 0.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/dest_rx_drain.sv
// dest_rx_drain: drains two destination FIFOs into a single receive port.
// Pops are combinational; FIFO data arrives one cycle after a pop and is
// registered, so a word popped in cycle N is presented on data_rx in N+2.
// Optional feature: define DEST_RX_DRAIN_CHECK_EN to check each word's
// destination bit against the FIFO it came from and stop in ERROR on a
// mismatch.
//
// Handshake: pop0/pop1 are read strobes toward FIFOs that present data the
// following cycle; valid_rx is a one-cycle strobe with no back-pressure,
// and rx_ready only gates new pops, so at most one word is in flight when
// the sink deasserts it.
module dest_rx_drain
    import dest_rx_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              empty0,
    input  logic              empty1,
    input  logic [DATA_W-1:0] data_out0,
    input  logic [DATA_W-1:0] data_out1,
    input  logic              rx_ready,
    output logic              pop0,
    output logic              pop1,
    output logic [DATA_W-1:0] data_rx,
    output logic              valid_rx,
    output logic              port_rx,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic              init_out,
    output logic              idle_out,
    output logic              active_out,
    output logic              error_out
);

    state_e              state_q, state_d;
    logic                inflight_q, inflight_d;
    logic                fl_port_q, fl_port_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                port_q, port_d;
    logic [CNT_W-1:0]    cnt0_q, cnt0_d;
    logic [CNT_W-1:0]    cnt1_q, cnt1_d;

    logic                pop_en;
    logic [1:0]          req;
    logic [1:0]          gnt;
    logic                pop_any;
    logic                rr_ptr;
    logic [DATA_W-1:0]   rx_word;
    logic                mismatch;
    logic                deliver;

    // Pop permission: init is also excluded because entering INIT forgets
    // the in-flight flag, which would silently lose a word popped that cycle.
    always_comb begin
        pop_en = !reset && !init && rx_ready &&
                 ((state_q == ST_IDLE) || (state_q == ST_ACTIVE));
        req    = {!empty1, !empty0} & {2{pop_en}};
    end

    rr_arb2 u_arb (
        .clk_i     (clk),
        .reset_i   (reset),
        .clear_i   (init),
        .req_i     (req),
        .advance_i (pop_any),
        .gnt_o     (gnt),
        .ptr_o     (rr_ptr)
    );

    assign pop_any = gnt[0] | gnt[1];
    assign pop0    = gnt[0];
    assign pop1    = gnt[1];

    // Select the returning word for the port popped last cycle and decide
    // whether it is delivered.
    always_comb begin
        rx_word = fl_port_q ? data_out1 : data_out0;
`ifdef DEST_RX_DRAIN_CHECK_EN
        mismatch = inflight_q && (rx_word[DEST_BIT] != fl_port_q);
`else
        mismatch = 1'b0;
`endif
        deliver = inflight_q && !mismatch && !init &&
                  ((state_q == ST_IDLE) || (state_q == ST_ACTIVE));
    end

    // FSM next state: init beats a mismatch, a mismatch beats normal flow.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE:   if (pop_any) state_d = ST_ACTIVE;
            ST_ACTIVE: if (empty0 && empty1 && !inflight_q) state_d = ST_IDLE;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_INIT;
        endcase
        if (mismatch) begin
            state_d = ST_ERROR;
        end
        if (init) begin
            state_d = ST_INIT;
        end
    end

    // Datapath next state: in-flight tracking, receive register, counters.
    always_comb begin
        inflight_d = pop_any;
        fl_port_d  = gnt[1];
        valid_d    = deliver;
        data_d     = data_q;
        port_d     = port_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        if (deliver) begin
            data_d = rx_word;
            port_d = fl_port_q;
            if (fl_port_q) begin
                cnt1_d = cnt1_q + CNT_W'(1);
            end else begin
                cnt0_d = cnt0_q + CNT_W'(1);
            end
        end
        if (init) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end
    end

    // State and datapath registers; reset discards any in-flight word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            inflight_q <= 1'b0;
            fl_port_q  <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            port_q     <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            fl_port_q  <= fl_port_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            port_q     <= port_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    // One-hot state indication and registered receive outputs.
    always_comb begin
        init_out   = (state_q == ST_INIT);
        idle_out   = (state_q == ST_IDLE);
        active_out = (state_q == ST_ACTIVE);
        error_out  = (state_q == ST_ERROR);
    end

    assign data_rx  = data_q;
    assign valid_rx = valid_q;
    assign port_rx  = port_q;
    assign cnt0     = cnt0_q;
    assign cnt1     = cnt1_q;

    // The pointer is observable only through grant order.
    logic unused_ptr;
    assign unused_ptr = rr_ptr;

endmodule

// File: tb/tb_dest_rx_drain.sv
// tb_dest_rx_drain: directed bench for dest_rx_drain with a transaction-level
// model (FIFO contents, one-cycle flight slot, abstract state) compared every
// cycle, plus literal expectations per scenario. DEST_RX_DRAIN_CHECK_EN
// selects the destination-check expectations.
`timescale 1ns/1ps
module tb_dest_rx_drain;

  localparam int DATA_W = 6;
  localparam int CNT_W  = 8;
`ifdef DEST_RX_DRAIN_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  localparam int M_INIT = 0, M_IDLE = 1, M_ACTIVE = 2, M_ERROR = 3;

  logic clk, reset, init, empty0, empty1, rx_ready;
  logic [DATA_W-1:0] data_out0, data_out1, data_rx;
  logic pop0, pop1, valid_rx, port_rx;
  logic [CNT_W-1:0] cnt0, cnt1;
  logic init_out, idle_out, active_out, error_out;

  dest_rx_drain #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .init(init),
    .empty0(empty0), .empty1(empty1),
    .data_out0(data_out0), .data_out1(data_out1),
    .rx_ready(rx_ready), .pop0(pop0), .pop1(pop1),
    .data_rx(data_rx), .valid_rx(valid_rx), .port_rx(port_rx),
    .cnt0(cnt0), .cnt1(cnt1),
    .init_out(init_out), .idle_out(idle_out),
    .active_out(active_out), .error_out(error_out)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // environment FIFOs and model copies of them
  logic [DATA_W-1:0] f0[$], f1[$];
  logic [DATA_W-1:0] m_f0[$], m_f1[$];
  // logs of observed DUT activity for literal checks
  int pop_cyc_q[$];
  bit pop_port_q[$];
  int rx_cyc_q[$];
  logic [DATA_W-1:0] rx_data_q[$];
  bit rx_port_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  logic p0, p1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO behaviour: empty flags follow contents, read data appears after a pop
  initial begin : fifo_env
    empty0 = 1'b1;
    empty1 = 1'b1;
    data_out0 = '0;
    data_out1 = '0;
    forever begin
      @(negedge clk);
      #1;
      empty0 = (f0.size() == 0);
      empty1 = (f1.size() == 0);
      #2;
      p0 = pop0;
      p1 = pop1;
      @(posedge clk);
      #1;
      if (p0 && f0.size() > 0) data_out0 = f0.pop_front();
      if (p1 && f1.size() > 0) data_out1 = f1.pop_front();
    end
  end

  // model state
  int m_st = M_INIT;
  bit m_ptr = 1'b0;
  int m_cnt0 = 0, m_cnt1 = 0;
  bit m_fl = 1'b0, m_fl_port = 1'b0;
  logic [DATA_W-1:0] m_fl_data = '0;
  bit m_valid = 1'b0, m_port = 1'b0;
  logic [DATA_W-1:0] m_data = '0;

  // scoreboard: compare every cycle, then advance the model across the edge
  initial begin : scoreboard
    bit e_p0, e_p1, arr, mis, both_empty;
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      e_p0 = 1'b0;
      e_p1 = 1'b0;
      if (!reset && !init && rx_ready && (m_st == M_IDLE || m_st == M_ACTIVE)) begin
        if (m_f0.size() > 0 && m_f1.size() > 0) begin
          if (m_ptr) e_p1 = 1'b1; else e_p0 = 1'b1;
        end else if (m_f0.size() > 0) e_p0 = 1'b1;
        else if (m_f1.size() > 0) e_p1 = 1'b1;
      end
      if (chk_en) begin
        check("pop0", pop0, e_p0);
        check("pop1", pop1, e_p1);
        check("valid_rx", valid_rx, m_valid);
        check("data_rx", data_rx, m_data);
        check("port_rx", port_rx, m_port);
        check("cnt0", cnt0, m_cnt0);
        check("cnt1", cnt1, m_cnt1);
        check("init_out", init_out, m_st == M_INIT);
        check("idle_out", idle_out, m_st == M_IDLE);
        check("active_out", active_out, m_st == M_ACTIVE);
        check("error_out", error_out, m_st == M_ERROR);
        if (pop0 || pop1) begin
          pop_cyc_q.push_back(cyc);
          pop_port_q.push_back(pop1);
        end
        if (valid_rx) begin
          rx_cyc_q.push_back(cyc);
          rx_data_q.push_back(data_rx);
          rx_port_q.push_back(port_rx);
        end
      end
      // model update for the coming edge
      if (reset) begin
        m_st = M_INIT; m_ptr = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
        m_fl = 1'b0; m_valid = 1'b0; m_data = '0; m_port = 1'b0;
      end else begin
        arr = m_fl;
        mis = CHECK && m_fl && (m_fl_data[4] != m_fl_port);
        both_empty = (m_f0.size() == 0) && (m_f1.size() == 0);
        m_valid = 1'b0;
        if (init) begin
          m_st = M_INIT; m_ptr = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
        end else begin
          if (arr && !mis && m_st != M_ERROR) begin
            m_valid = 1'b1;
            m_data = m_fl_data;
            m_port = m_fl_port;
            if (m_fl_port) m_cnt1 = (m_cnt1 + 1) % (1 << CNT_W);
            else m_cnt0 = (m_cnt0 + 1) % (1 << CNT_W);
          end
          if (mis) m_st = M_ERROR;
          else if (m_st == M_INIT) m_st = M_IDLE;
          else if (m_st == M_IDLE && (e_p0 || e_p1)) m_st = M_ACTIVE;
          else if (m_st == M_ACTIVE && both_empty && !arr) m_st = M_IDLE;
          if (e_p0 || e_p1) m_ptr = ~m_ptr;
        end
        m_fl = e_p0 || e_p1;
        m_fl_port = e_p1;
        if (e_p0) m_fl_data = m_f0.pop_front();
        else if (e_p1) m_fl_data = m_f1.pop_front();
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push0(input logic [DATA_W-1:0] w);
    f0.push_back(w);
    m_f0.push_back(w);
  endtask

  task automatic push1(input logic [DATA_W-1:0] w);
    f1.push_back(w);
    m_f1.push_back(w);
  endtask

  task automatic clear_logs();
    pop_cyc_q.delete(); pop_port_q.delete();
    rx_cyc_q.delete(); rx_data_q.delete(); rx_port_q.delete();
  endtask

  task automatic do_init();
    tick(1);
    init = 1'b1;
    tick(1);
    init = 1'b0;
    tick(1);
  endtask

  initial begin : main
    logic [DATA_W-1:0] w;
    reset = 1'b1;
    init = 1'b0;
    rx_ready = 1'b1;

    // reset state
    tick(2);
    chk_en = 1'b1;
    #2;
    check("rst_init_out", init_out, 1);
    check("rst_pops", {pop1, pop0}, 0);
    check("rst_valid", valid_rx, 0);
    check("rst_data", data_rx, 0);
    check("rst_port", port_rx, 0);
    check("rst_cnt", {cnt1, cnt0}, 0);
    check("rst_error", error_out, 0);

    // init pulse: INIT then IDLE
    tick(1);
    reset = 1'b0;
    init = 1'b1;
    tick(1);
    init = 1'b0;
    #2;
    check("init_state", init_out, 1);
    tick(1);
    #2;
    check("after_init_idle", idle_out, 1);

    // two words from FIFO0
    tick(1);
    clear_logs();
    push0(6'h03);
    push0(6'h2D);
    tick(8);
    #2;
    check("s2_rx_count", rx_data_q.size(), 2);
    check("s2_rx0", rx_data_q[0], 6'h03);
    check("s2_rx1", rx_data_q[1], 6'h2D);
    check("s2_port", {rx_port_q[1], rx_port_q[0]}, 0);
    check("s2_pop_gap", pop_cyc_q[1] - pop_cyc_q[0], 1);
    check("s2_latency", rx_cyc_q[0] - pop_cyc_q[0], 2);
    check("s2_cnt0", cnt0, 2);
    check("s2_idle", idle_out, 1);

    // both FIFOs: alternating grants
    do_init();
    clear_logs();
    push0(6'h03); push0(6'h2D);
    push1(6'h1B); push1(6'h3B);
    tick(10);
    #2;
    check("s3_pop_count", pop_port_q.size(), 4);
    check("s3_pop_order", {pop_port_q[3], pop_port_q[2], pop_port_q[1], pop_port_q[0]}, 4'b1010);
    check("s3_rx2", rx_data_q[1], 6'h1B);
    check("s3_cnt0", cnt0, 2);
    check("s3_cnt1", cnt1, 2);

    // rx_ready dropped one cycle after a pop
    do_init();
    clear_logs();
    push0(6'h01); push0(6'h02); push0(6'h03);
    tick(1);
    rx_ready = 1'b0;
    tick(6);
    #2;
    check("s4_pops_held", pop_cyc_q.size(), 1);
    check("s4_one_rx", rx_data_q.size(), 1);
    check("s4_rx0", rx_data_q[0], 6'h01);
    tick(1);
    rx_ready = 1'b1;
    tick(8);
    #2;
    check("s4_rx_all", rx_data_q.size(), 3);
    check("s4_cnt0", cnt0, 3);

    // destination mismatch on FIFO0
    do_init();
    clear_logs();
    push0(6'h1B); push0(6'h05);
    tick(6);
    #2;
`ifdef DEST_RX_DRAIN_CHECK_EN
    check("s5_no_rx", rx_data_q.size(), 0);
    check("s5_error", error_out, 1);
    check("s5_cnt0", cnt0, 0);
`else
    check("s5_rx", rx_data_q.size(), 2);
    check("s5_error", error_out, 0);
    check("s5_cnt0", cnt0, 2);
`endif
    tick(1);
    push1(6'h1B);
    tick(5);
    #2;
`ifdef DEST_RX_DRAIN_CHECK_EN
    check("s5_pops_stop", pop_cyc_q.size(), 2);
`else
    check("s5_pops", pop_cyc_q.size(), 3);
`endif
    tick(1);
    init = 1'b1;
    tick(1);
    init = 1'b0;
    #2;
    check("s5_init", init_out, 1);
    check("s5_clr", {cnt1, cnt0}, 0);
    tick(6);
    #2;
    check("s5_final_rx", rx_data_q.size(), CHECK ? 1 : 3);
    check("s5_idle", idle_out, 1);

    // cnt1 wrap
    do_init();
    clear_logs();
    for (int i = 0; i < 255; i++) begin
      w = 6'h10 | 6'(i & 15) | 6'((i & 1) << 5);
      push1(w);
    end
    tick(262);
    #2;
    check("s6_cnt1_255", cnt1, 255);
    tick(1);
    push1(6'h1F);
    tick(5);
    #2;
    check("s6_cnt1_wrap", cnt1, 0);
    check("s6_rx_count", rx_data_q.size(), 256);

    // reset between pop and data return
    do_init();
    clear_logs();
    push0(6'h07);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(4);
    #2;
    check("s7_pop", pop_cyc_q.size(), 1);
    check("s7_no_rx", rx_data_q.size(), 0);
    check("s7_cnt0", cnt0, 0);
    check("s7_data", data_rx, 0);
    check("s7_idle", idle_out, 1);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
